// File: rtl/lcd_fifo_wr_ctl_hys.sv
// rtl/lcd_fifo_wr_ctl_hys.sv - frame-aligned AXI-stream to LCD line FIFO write gate with request hysteresis
// Optional frame/drop statistics outputs are enabled by defining LCD_FIFO_WR_STATS_EN.
module lcd_fifo_wr_ctl_hys #(
  parameter int CNT_W                 = 10,
  parameter int FIFO_ALMOSTFULL_DEPTH = 1000,
  parameter int FIFO_RESUME_DEPTH     = 960,
  parameter int H_PIXELS              = 800,
  parameter int V_LINES               = 480
) (
  input  logic             fifo_wr_clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             axis_data_en,
  input  logic             axis_data_sync,
  output logic             axis_data_requst,
  output logic             fifo_wr_en,
  input  logic             fifo_full,
  input  logic [CNT_W-1:0] fifo_wr_cnt,
  output logic             lcd_framesync,
  output logic             line_end,
  output logic             ovf_err,
  output logic             sync_err,
`ifdef LCD_FIFO_WR_STATS_EN
  output logic [31:0]      frame_cnt,
  output logic [31:0]      drop_cnt,
`endif
  input  logic             err_clr
);

  localparam int PW = (H_PIXELS > 1) ? $clog2(H_PIXELS) : 1;
  localparam int LW = (V_LINES > 1) ? $clog2(V_LINES) : 1;
  localparam logic [PW-1:0]    H_LAST  = PW'(H_PIXELS - 1);
  localparam logic [LW-1:0]    V_LAST  = LW'(V_LINES - 1);
  localparam logic [CNT_W-1:0] AF_LVL  = CNT_W'(FIFO_ALMOSTFULL_DEPTH);
  localparam logic [CNT_W-1:0] RES_LVL = CNT_W'(FIFO_RESUME_DEPTH);

  typedef enum logic [1:0] {IDLE, SEEK, STREAM} state_t;
  state_t state, state_nxt;

  logic [PW-1:0] pix_cnt, cur_pix;
  logic [LW-1:0] line_cnt, cur_line;
  logic          requst_q, requst_d;
  logic          acc, sync_acc, pos_beat, at_origin, pix_last, frame_done;

  assign axis_data_requst = requst_q;

  // pos_beat marks beats that occupy a frame position; a sync beat always lands at 0/0
  always_comb begin
    acc        = axis_data_en & requst_q;
    sync_acc   = acc & axis_data_sync;
    pos_beat   = ((state == SEEK) & sync_acc) | ((state == STREAM) & acc);
    at_origin  = (pix_cnt == '0) && (line_cnt == '0);
    cur_pix    = sync_acc ? '0 : pix_cnt;
    cur_line   = sync_acc ? '0 : line_cnt;
    pix_last   = (cur_pix == H_LAST);
    frame_done = pos_beat & pix_last & (cur_line == V_LAST);
    fifo_wr_en = pos_beat & ~fifo_full;
  end

  always_ff @(posedge fifo_wr_clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!enable) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    state_nxt = SEEK;
        SEEK:    if (sync_acc && !frame_done) state_nxt = STREAM;
        STREAM:  if (frame_done) state_nxt = SEEK;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Request: forced high in SEEK, hysteresis between resume and almost-full levels in STREAM
  always_comb begin
    requst_d = 1'b0;
    if (enable) begin
      case (state)
        SEEK:   requst_d = 1'b1;
        STREAM: begin
          if (frame_done)                  requst_d = 1'b1;
          else if (fifo_wr_cnt >= AF_LVL)  requst_d = 1'b0;
          else if (fifo_wr_cnt < RES_LVL)  requst_d = 1'b1;
          else                             requst_d = requst_q;
        end
        default: requst_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge fifo_wr_clk or negedge rst_n) begin
    if (!rst_n) begin
      requst_q      <= 1'b0;
      pix_cnt       <= '0;
      line_cnt      <= '0;
      lcd_framesync <= 1'b0;
      line_end      <= 1'b0;
      ovf_err       <= 1'b0;
      sync_err      <= 1'b0;
    end else begin
      requst_q      <= requst_d;
      lcd_framesync <= fifo_wr_en & (cur_pix == '0) & (cur_line == '0);
      line_end      <= pos_beat & pix_last;
      ovf_err       <= (pos_beat & fifo_full) | (ovf_err & ~err_clr);
      sync_err      <= ((state == STREAM) & sync_acc & ~at_origin) | (sync_err & ~err_clr);
      if (!enable) begin
        pix_cnt  <= '0;
        line_cnt <= '0;
      end else if (pos_beat) begin
        if (pix_last) begin
          pix_cnt  <= '0;
          line_cnt <= (cur_line == V_LAST) ? '0 : cur_line + 1'b1;
        end else begin
          pix_cnt  <= cur_pix + 1'b1;
          line_cnt <= cur_line;
        end
      end
    end
  end

`ifdef LCD_FIFO_WR_STATS_EN
  logic drop_inc;
  assign drop_inc = ((state == SEEK) & acc & ~axis_data_sync) | (pos_beat & fifo_full);

  always_ff @(posedge fifo_wr_clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
      drop_cnt  <= '0;
    end else if (err_clr) begin
      frame_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      if (frame_done && frame_cnt != '1) frame_cnt <= frame_cnt + 1'b1;
      if (drop_inc && drop_cnt != '1)    drop_cnt  <= drop_cnt + 1'b1;
    end
  end
`endif

endmodule
